fault_locator: RTL and testbench

Serial response analyzer that recovers a single stuck-at fault from scan-out data. It receives observed and expected bits shifted out of a WIDTH-bit chain and accumulates mismatches over a multi-pattern session. At the end it reports the faulty bit index and stuck-at value, using the same encoding the injector side consumes (index and SA value). It sits on the capture/compare side of the scan-coverage bench, after the chain output and the golden-response source.

---
 rtl/fault_locator.sv | 171 +++++++++++++++++
 tb/tb_fault_locator.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_locator.sv
// fault_locator: serial scan-response analyzer that recovers a single
// stuck-at fault (bit index + stuck value) from obs/exp bit streams.
// Ports: clk, rst (async, active-high), start, bit_valid/bit_ready,
//   obs_bit, exp_bit, last in; busy, done, fault_found, fault_idx,
//   fault_sa_value, multi_fault, consistency_err, mismatch_count,
//   pattern_count out.
// Optional: define FAULT_LOCATOR_CONSISTENCY_EN to build the seen0/seen1
//   history and drive consistency_err; otherwise consistency_err is 0.
module fault_locator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  input  logic                     obs_bit,
  input  logic                     exp_bit,
  input  logic                     last,
  output logic                     busy,
  output logic                     done,
  output logic                     fault_found,
  output logic [$clog2(WIDTH)-1:0] fault_idx,
  output logic                     fault_sa_value,
  output logic                     multi_fault,
  output logic                     consistency_err,
  output logic [CNT_W-1:0]         mismatch_count,
  output logic [CNT_W-1:0]         pattern_count
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_POS = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] bit_pos;
  logic          accept;
  logic          mis;
  logic          wrap;
  logic          finish;

  // start wins over a colliding bit
  assign accept = bit_valid && bit_ready && !start;
  assign mis    = accept && (obs_bit != exp_bit);
  assign wrap   = accept && (bit_pos == LAST_POS);
  assign finish = wrap && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bit_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bit_pos        <= '0;
      fault_found    <= 1'b0;
      fault_idx      <= '0;
      fault_sa_value <= 1'b0;
      multi_fault    <= 1'b0;
      mismatch_count <= '0;
      pattern_count  <= '0;
    end else if (start) begin
      state          <= SHIFT;
      bit_ready      <= 1'b1;
      busy           <= 1'b1;
      done           <= 1'b0;
      bit_pos        <= '0;
      fault_found    <= 1'b0;
      fault_idx      <= '0;
      fault_sa_value <= 1'b0;
      multi_fault    <= 1'b0;
      mismatch_count <= '0;
      pattern_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        SHIFT: begin
          if (finish) begin
            state     <= DONE;
            bit_ready <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bit_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase

      if (accept) begin
        bit_pos <= wrap ? '0 : bit_pos + 1'b1;
        if (wrap && pattern_count != '1)
          pattern_count <= pattern_count + 1'b1;
      end

      if (mis) begin
        if (mismatch_count != '1)
          mismatch_count <= mismatch_count + 1'b1;
        // candidate is frozen after the first capture
        if (!fault_found) begin
          fault_found    <= 1'b1;
          fault_idx      <= bit_pos;
          fault_sa_value <= obs_bit;
        end else if (bit_pos != fault_idx ||
                     obs_bit != fault_sa_value) begin
          multi_fault <= 1'b1;
        end
      end
    end
  end

`ifdef FAULT_LOCATOR_CONSISTENCY_EN
  logic [WIDTH-1:0] seen0;
  logic [WIDTH-1:0] seen1;
  logic [WIDTH-1:0] seen0_nxt;
  logic [WIDTH-1:0] seen1_nxt;
  logic [WIDTH-1:0] pos_mask;
  logic             cand_found;
  logic [IW-1:0]    cand_idx;
  logic             cand_sa;

  // look-ahead values so the final bit is part of the check
  always_comb begin
    pos_mask = '0;
    if (accept)
      pos_mask[bit_pos] = 1'b1;
    seen0_nxt  = seen0 | (pos_mask & {WIDTH{~obs_bit}});
    seen1_nxt  = seen1 | (pos_mask & {WIDTH{obs_bit}});
    cand_found = fault_found | mis;
    cand_idx   = fault_found ? fault_idx : bit_pos;
    cand_sa    = fault_found ? fault_sa_value : obs_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen0           <= '0;
      seen1           <= '0;
      consistency_err <= 1'b0;
    end else if (start) begin
      seen0           <= '0;
      seen1           <= '0;
      consistency_err <= 1'b0;
    end else begin
      if (accept) begin
        seen0 <= seen0_nxt;
        seen1 <= seen1_nxt;
      end
      // a stuck node can never show the opposite value
      if (finish)
        consistency_err <= cand_found &&
          (cand_sa ? seen0_nxt[cand_idx] : seen1_nxt[cand_idx]);
    end
  end
`else
  assign consistency_err = 1'b0;
`endif

endmodule

// File: tb/tb_fault_locator.sv
// tb_fault_locator: randomized + directed bench for fault_locator,
// checked every cycle against a session-history reference model.
module tb_fault_locator;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic          obs_bit = 1'b0;
  logic          exp_bit = 1'b0;
  logic          last = 1'b0;
  logic          busy;
  logic          done;
  logic          fault_found;
  logic [2:0]    fault_idx;
  logic          fault_sa_value;
  logic          multi_fault;
  logic          consistency_err;
  logic [CW-1:0] mismatch_count;
  logic [CW-1:0] pattern_count;

  int tests = 0;
  int fails = 0;

  fault_locator #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .obs_bit(obs_bit),
    .exp_bit(exp_bit),
    .last(last),
    .busy(busy),
    .done(done),
    .fault_found(fault_found),
    .fault_idx(fault_idx),
    .fault_sa_value(fault_sa_value),
    .multi_fault(multi_fault),
    .consistency_err(consistency_err),
    .mismatch_count(mismatch_count),
    .pattern_count(pattern_count)
  );

  always #5 clk = ~clk;

`ifdef FAULT_LOCATOR_CONSISTENCY_EN
  localparam bit CONS_ON = 1'b1;
`else
  localparam bit CONS_ON = 1'b0;
`endif

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, expv, $time);
    end
  endtask

  // Model: accepted-bit history of the current session
  typedef struct packed {
    logic obs;
    logic exp;
  } bit_t;

  bit_t q[$];
  int   m_phase = 0; // 0 idle, 1 shifting, 2 done cycle
  logic m_cons = 1'b0;

  function automatic int first_mis();
    foreach (q[i]) if (q[i].obs != q[i].exp) return i;
    return -1;
  endfunction

  // a stuck node must never have shown the opposite value anywhere
  function automatic logic cons_of_q();
    int fm;
    fm = first_mis();
    if (!CONS_ON || fm < 0) return 1'b0;
    foreach (q[k])
      if (k % W == fm % W && q[k].obs != q[fm].obs) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      q.delete();
      m_cons = 1'b0;
    end else if (start) begin
      m_phase = 1;
      q.delete();
      m_cons = 1'b0;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1 && bit_valid) begin
      q.push_back('{obs: obs_bit, exp: exp_bit});
      if (q.size() % W == 0 && last) begin
        m_phase = 2;
        m_cons = cons_of_q();
      end
    end
  end

  always @(negedge clk) begin
    int fm;
    int mc;
    logic mf;
    fm = first_mis();
    mc = 0;
    mf = 1'b0;
    foreach (q[i]) begin
      if (q[i].obs != q[i].exp) begin
        mc++;
        if (i > fm && (i % W != fm % W || q[i].obs != q[fm].obs))
          mf = 1'b1;
      end
    end
    chk("busy", busy, m_phase != 0);
    chk("bit_ready", bit_ready, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("fault_found", fault_found, fm >= 0);
    chk("fault_idx", fault_idx, fm >= 0 ? fm % W : 0);
    chk("fault_sa", fault_sa_value, fm >= 0 ? q[fm].obs : 1'b0);
    chk("multi_fault", multi_fault, mf);
    chk("mismatch_count", mismatch_count, mc);
    chk("pattern_count", pattern_count, q.size() / W);
    chk("consistency_err", consistency_err, m_cons);
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pattern(logic [W-1:0] o, logic [W-1:0] e,
                              bit lastp, bit gaps);
    for (int i = 0; i < W; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bit_valid = 1'b0;
          last = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      bit_valid = 1'b1;
      obs_bit = o[i];
      exp_bit = e[i];
      last = (i == W - 1) ? lastp : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_done(output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bit_valid = 1'b0;
      last = 1'b0;
      cyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", ok, 1'b1);
  endtask

  task automatic chk_result(string tag, logic f, int idx, logic sa,
                            logic mf, int mc, int pc);
    chk({tag, ".found"}, fault_found, f);
    chk({tag, ".idx"}, fault_idx, idx);
    chk({tag, ".sa"}, fault_sa_value, sa);
    chk({tag, ".multi"}, multi_fault, mf);
    chk({tag, ".mcount"}, mismatch_count, mc);
    chk({tag, ".pcount"}, pattern_count, pc);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] o;
    logic [W-1:0] e;
    logic [W-1:0] fmask;
    int p;
    int mode;
    int npat;
    logic v;
    bit gaps;

    repeat (2) @(negedge clk);
    chk_result("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.busy", busy, 0);
    rst = 1'b0;

    // bits offered while idle must be ignored
    repeat (3) begin
      @(negedge clk);
      bit_valid = 1'b1;
      obs_bit = 1'b1;
      exp_bit = 1'b0;
    end

    // clean run
    do_start();
    for (int k = 0; k < 3; k++) send_pattern(8'h5A, 8'h5A, k == 2, 0);
    wait_done(cyc);
    chk("clean.latency", cyc, 1);
    chk_result("clean", 0, 0, 0, 0, 0, 3);

    // SA1 at index 5
    do_start();
    for (int k = 0; k < 2; k++) send_pattern(8'h20, 8'h00, k == 1, 0);
    wait_done(cyc);
    chk_result("sa1", 1, 5, 1, 0, 2, 2);

    // same with handshake gaps
    do_start();
    for (int k = 0; k < 2; k++) send_pattern(8'h20, 8'h00, k == 1, 1);
    wait_done(cyc);
    chk_result("sa1_gaps", 1, 5, 1, 0, 2, 2);

    // double fault
    do_start();
    send_pattern(8'hFB, 8'hFF, 0, 0);
    send_pattern(8'h40, 8'h00, 1, 0);
    wait_done(cyc);
    chk_result("double", 1, 2, 0, 1, 2, 2);

    // consistency
    do_start();
    send_pattern(8'h08, 8'h08, 0, 0);
    send_pattern(8'hF7, 8'hFF, 1, 0);
    wait_done(cyc);
    chk_result("cons", 1, 3, 0, 0, 1, 2);
    chk("cons.err", consistency_err, CONS_ON);

    // start collides with a mismatching bit mid-pattern
    do_start();
    send_pattern(8'h00, 8'h01, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      obs_bit = 1'b1;
      exp_bit = 1'b0;
      last = 1'b1;
    end
    @(negedge clk);
    start = 1'b1;
    bit_valid = 1'b1;
    obs_bit = 1'b1;
    exp_bit = 1'b0;
    @(negedge clk);
    start = 1'b0;
    bit_valid = 1'b0;
    chk_result("collide", 0, 0, 0, 0, 0, 0);
    chk("collide.busy", busy, 1);
    send_pattern(8'hC3, 8'hC3, 1, 0);
    wait_done(cyc);
    chk_result("collide_end", 0, 0, 0, 0, 0, 1);

    // async reset mid-pattern
    do_start();
    send_pattern(8'hFF, 8'h00, 0, 0);
    @(negedge clk);
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_result("areset", 0, 0, 0, 0, 0, 0);
    chk("areset.busy", busy, 0);
    chk("areset.ready", bit_ready, 0);
    #1 rst = 1'b0;
    do_start();
    for (int k = 0; k < 2; k++) send_pattern(8'h20, 8'h00, k == 1, 0);
    wait_done(cyc);
    chk_result("post_reset", 1, 5, 1, 0, 2, 2);

    // randomized sessions against the model
    for (int s = 0; s < 40; s++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bit_valid = 1'($urandom_range(0, 1));
        obs_bit = 1'($urandom_range(0, 1));
        exp_bit = 1'($urandom_range(0, 1));
      end
      do_start();
      npat = $urandom_range(1, 4);
      mode = $urandom_range(0, 2);
      p = $urandom_range(0, W - 1);
      v = 1'($urandom_range(0, 1));
      gaps = 1'($urandom_range(0, 1));
      for (int k = 0; k < npat; k++) begin
        e = W'($urandom);
        o = e;
        if (mode == 1) o[p] = v;
        if (mode == 2 && $urandom_range(0, 2) == 0) begin
          fmask = '0;
          fmask[$urandom_range(0, W - 1)] = 1'b1;
          o = e ^ fmask;
        end
        send_pattern(o, e, k == npat - 1, gaps);
      end
      wait_done(cyc);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
